// File: rtl/color_binarize.sv
// color_binarize: upstream stage of the colour-detect overlay renderer.
// Registers the camera pixel stream, flags pixels whose RGB value lies
// inside a programmable inclusive window, tags each pixel with its (h,v)
// coordinate and counts matched pixels inside a centre ROI square once per
// frame.
// Optional build macro: COLOR_BIN_MAJORITY_EN adds a 3-tap horizontal
// majority filter on the match bit and one extra cycle of latency.
module color_binarize #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int ROI_HALF   = 16,
    parameter int HIT_THRESH = 64
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        de_in,
    input  logic        vsync_in,
    input  logic [23:0] rgb_in,
    input  logic [7:0]  r_min,
    input  logic [7:0]  r_max,
    input  logic [7:0]  g_min,
    input  logic [7:0]  g_max,
    input  logic [7:0]  b_min,
    input  logic [7:0]  b_max,
    output logic        de_out,
    output logic        vsync_out,
    output logic [23:0] rgb_out,
    output logic        Binary_out,
    output logic [11:0] h_cnt,
    output logic [10:0] v_cnt,
    output logic [10:0] roi_count,
    output logic        detected
);

    localparam logic [11:0] H_LAST   = 12'(IMG_WIDTH - 1);
    localparam logic [10:0] V_LAST   = 11'(IMG_HEIGHT - 1);
    localparam logic [11:0] ROI_H_LO = 12'(IMG_WIDTH / 2 - ROI_HALF);
    localparam logic [11:0] ROI_H_HI = 12'(IMG_WIDTH / 2 + ROI_HALF);
    localparam logic [10:0] ROI_V_LO = 11'(IMG_HEIGHT / 2 - ROI_HALF);
    localparam logic [10:0] ROI_V_HI = 11'(IMG_HEIGHT / 2 + ROI_HALF);
    localparam logic [10:0] ACC_MAX  = 11'h7FF;
    localparam logic [10:0] HIT_LVL  = 11'(HIT_THRESH);

    // Majority of three bits.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // ---------------------------------------------------------------
    // Input-side coordinate counters (position of the next de pixel)
    // ---------------------------------------------------------------
    logic [11:0] r_h_in;
    logic [10:0] r_v_in;

    // Advance the raster position on every active pixel; vsync restarts it.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_h_in <= 12'd0;
            r_v_in <= 11'd0;
        end else if (vsync_in) begin
            r_h_in <= 12'd0;
            r_v_in <= 11'd0;
        end else if (de_in) begin
            if (r_h_in == H_LAST) begin
                r_h_in <= 12'd0;
                r_v_in <= (r_v_in == V_LAST) ? 11'd0 : r_v_in + 11'd1;
            end else begin
                r_h_in <= r_h_in + 12'd1;
                r_v_in <= r_v_in;
            end
        end else begin
            r_h_in <= r_h_in;
            r_v_in <= r_v_in;
        end
    end

    // ---------------------------------------------------------------
    // Stage 1: register the pixel, its tag and the six window compares.
    // A pixel arriving together with vsync_in keeps the tag the counters
    // held in that cycle; the clear takes effect for the following pixel.
    // ---------------------------------------------------------------
    logic        r_s1_de;
    logic        r_s1_vs;
    logic [23:0] r_s1_rgb;
    logic [11:0] r_s1_h;
    logic [10:0] r_s1_v;
    logic [5:0]  r_s1_cmp;

    // Capture the input pixel and its per-channel bound compares.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_s1_de  <= 1'b0;
            r_s1_vs  <= 1'b0;
            r_s1_rgb <= 24'd0;
            r_s1_h   <= 12'd0;
            r_s1_v   <= 11'd0;
            r_s1_cmp <= 6'd0;
        end else begin
            r_s1_de     <= de_in;
            r_s1_vs     <= vsync_in;
            r_s1_rgb    <= rgb_in;
            r_s1_h      <= r_h_in;
            r_s1_v      <= r_v_in;
            r_s1_cmp[0] <= (rgb_in[23:16] >= r_min);
            r_s1_cmp[1] <= (rgb_in[23:16] <= r_max);
            r_s1_cmp[2] <= (rgb_in[15:8]  >= g_min);
            r_s1_cmp[3] <= (rgb_in[15:8]  <= g_max);
            r_s1_cmp[4] <= (rgb_in[7:0]   >= b_min);
            r_s1_cmp[5] <= (rgb_in[7:0]   <= b_max);
        end
    end

    // Raw match is forced low on blanking cycles so it never leaks out.
    logic w_s1_match;
    logic w_s1_roi;
    assign w_s1_match = r_s1_de & (&r_s1_cmp);
    assign w_s1_roi   = (r_s1_h >= ROI_H_LO) && (r_s1_h <= ROI_H_HI) &&
                        (r_s1_v >= ROI_V_LO) && (r_s1_v <= ROI_V_HI);

    // Signals feeding the output register stage.
    logic        w_o_de;
    logic        w_o_vs;
    logic [23:0] w_o_rgb;
    logic [11:0] w_o_h;
    logic [10:0] w_o_v;
    logic        w_o_bin;
    logic        w_o_roi;

`ifdef COLOR_BIN_MAJORITY_EN
    // ---------------------------------------------------------------
    // Extra stage: centre pixel of the 3-tap majority window.
    // Left neighbour is the pixel held here one cycle earlier, right
    // neighbour is the pixel currently in stage 1; a blank cycle or a
    // line edge on either side contributes a 0.
    // ---------------------------------------------------------------
    logic        r_s2_de;
    logic        r_s2_vs;
    logic [23:0] r_s2_rgb;
    logic [11:0] r_s2_h;
    logic [10:0] r_s2_v;
    logic        r_s2_match;
    logic        r_s2_roi;
    logic        r_s2_left;
    logic        w_left;
    logic        w_right;

    // Hold the centre pixel and remember the match of the one before it.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_s2_de    <= 1'b0;
            r_s2_vs    <= 1'b0;
            r_s2_rgb   <= 24'd0;
            r_s2_h     <= 12'd0;
            r_s2_v     <= 11'd0;
            r_s2_match <= 1'b0;
            r_s2_roi   <= 1'b0;
            r_s2_left  <= 1'b0;
        end else begin
            r_s2_de    <= r_s1_de;
            r_s2_vs    <= r_s1_vs;
            r_s2_rgb   <= r_s1_rgb;
            r_s2_h     <= r_s1_h;
            r_s2_v     <= r_s1_v;
            r_s2_match <= w_s1_match;
            r_s2_roi   <= w_s1_roi;
            r_s2_left  <= r_s2_de & r_s2_match;
        end
    end

    assign w_left  = r_s2_left & (r_s2_h != 12'd0);
    assign w_right = w_s1_match & (r_s2_h != H_LAST);
    assign w_o_de  = r_s2_de;
    assign w_o_vs  = r_s2_vs;
    assign w_o_rgb = r_s2_rgb;
    assign w_o_h   = r_s2_h;
    assign w_o_v   = r_s2_v;
    assign w_o_bin = r_s2_de & maj3(w_left, r_s2_match, w_right);
    assign w_o_roi = r_s2_roi;
`else
    assign w_o_de  = r_s1_de;
    assign w_o_vs  = r_s1_vs;
    assign w_o_rgb = r_s1_rgb;
    assign w_o_h   = r_s1_h;
    assign w_o_v   = r_s1_v;
    assign w_o_bin = w_s1_match;
    assign w_o_roi = w_s1_roi;
`endif

    // ---------------------------------------------------------------
    // Output stage: all pixel-aligned outputs leave from one register rank
    // ---------------------------------------------------------------
    logic        r_de_o;
    logic        r_vs_o;
    logic [23:0] r_rgb_o;
    logic [11:0] r_h_o;
    logic [10:0] r_v_o;
    logic        r_bin_o;
    logic        r_roi_o;

    // Register the aligned pixel outputs and the ROI membership of the pixel.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_de_o  <= 1'b0;
            r_vs_o  <= 1'b0;
            r_rgb_o <= 24'd0;
            r_h_o   <= 12'd0;
            r_v_o   <= 11'd0;
            r_bin_o <= 1'b0;
            r_roi_o <= 1'b0;
        end else begin
            r_de_o  <= w_o_de;
            r_vs_o  <= w_o_vs;
            r_rgb_o <= w_o_rgb;
            r_h_o   <= w_o_h;
            r_v_o   <= w_o_v;
            r_bin_o <= w_o_bin;
            r_roi_o <= w_o_roi;
        end
    end

    // ---------------------------------------------------------------
    // ROI accumulator and per-frame latch
    // ---------------------------------------------------------------
    logic        r_vs_d;
    logic [10:0] r_acc;
    logic [10:0] r_roi_count;
    logic        r_detected;
    logic        w_qual;
    logic        w_vs_rise;

    assign w_qual    = r_de_o & r_bin_o & r_roi_o;
    assign w_vs_rise = r_vs_o & ~r_vs_d;

    // Count qualifying ROI pixels; publish and restart on vsync_out rising.
    // A qualifying pixel in the latch cycle opens the new frame's count.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_vs_d      <= 1'b0;
            r_acc       <= 11'd0;
            r_roi_count <= 11'd0;
            r_detected  <= 1'b0;
        end else begin
            r_vs_d <= r_vs_o;
            if (w_vs_rise) begin
                r_roi_count <= r_acc;
                r_detected  <= (r_acc >= HIT_LVL);
                r_acc       <= w_qual ? 11'd1 : 11'd0;
            end else if (w_qual && (r_acc != ACC_MAX)) begin
                r_acc <= r_acc + 11'd1;
            end else begin
                r_acc <= r_acc;
            end
        end
    end

    assign de_out     = r_de_o;
    assign vsync_out  = r_vs_o;
    assign rgb_out    = r_rgb_o;
    assign Binary_out = r_bin_o;
    assign h_cnt      = r_h_o;
    assign v_cnt      = r_v_o;
    assign roi_count  = r_roi_count;
    assign detected   = r_detected;

endmodule
